// File: rtl/fir_lms_update.sv
// fir_lms_update: LMS error/adaptation stage; pairs y with d, updates w[] and streams new taps in order.
module fir_lms_update #(
    parameter int MAX_TAPS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        tap_count_i,
    input  logic [4:0]         mu_shift_i,
    input  logic               adapt_en_i,
    input  logic               clear_coeffs_i,
    input  logic signed [31:0] x_data_i,
    input  logic               x_valid_i,
    input  logic signed [31:0] y_data_i,
    input  logic               y_valid_i,
    input  logic signed [31:0] d_data_i,
    input  logic               d_valid_i,
    output logic signed [31:0] error_out_o,
    output logic               error_valid_o,
    output logic signed [31:0] coeff_out_o,
    output logic               coeff_out_valid_o,
    input  logic               coeff_out_ready_i,
    output logic               coeff_first_o,
    output logic               busy_o,
    output logic               overrun_o
);
    localparam int AW = $clog2(MAX_TAPS);
    localparam int KW = AW + 1;
    typedef enum logic {IDLE, UPDATE} state_t;
    state_t             state_q;
    logic signed [31:0] w_q [MAX_TAPS];
    logic signed [31:0] hist_q [MAX_TAPS];
    logic [AW-1:0]      wr_ptr_q;
    logic signed [31:0] y_pend_q, d_pend_q, err_q, coeff_q;
    logic               y_have_q, d_have_q, err_valid_q, coeff_valid_q, coeff_first_q, overrun_q;
    logic [KW-1:0]      taps_q, k_q;
    logic [4:0]         mu_q;
    logic [KW-1:0]      taps_d;
    logic [AW-1:0]      rd_idx;
    logic signed [63:0] prod;
    logic signed [31:0] err_d, delta_d, w_d;
    logic               pair, free;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        return (v[63:31] == {33{v[63]}}) ? v[31:0] : (v[63] ? 32'sh8000_0000 : 32'sh7FFF_FFFF);
    endfunction

    always_comb begin
        taps_d  = (tap_count_i == 32'd0 || tap_count_i > 32'(MAX_TAPS)) ? KW'(MAX_TAPS) : tap_count_i[KW-1:0];
        rd_idx  = wr_ptr_q - AW'(1) - k_q[AW-1:0];
        prod    = 64'(err_q) * 64'(hist_q[rd_idx]);
        delta_d = sat32(prod >>> mu_q);
        w_d     = sat32(64'(w_q[k_q[AW-1:0]]) + 64'(delta_d));
        err_d   = sat32(64'(d_pend_q) - 64'(y_pend_q));
        pair    = y_have_q && d_have_q;
        free    = !coeff_valid_q || coeff_out_ready_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            for (int i = 0; i < MAX_TAPS; i++) begin
                w_q[i]    <= '0;
                hist_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            y_pend_q      <= '0;
            d_pend_q      <= '0;
            err_q         <= '0;
            coeff_q       <= '0;
            y_have_q      <= 1'b0;
            d_have_q      <= 1'b0;
            err_valid_q   <= 1'b0;
            coeff_valid_q <= 1'b0;
            coeff_first_q <= 1'b0;
            overrun_q     <= 1'b0;
            taps_q        <= '0;
            k_q           <= '0;
            mu_q          <= '0;
        end else begin
            err_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (x_valid_i) begin
                    hist_q[wr_ptr_q] <= x_data_i;
                    wr_ptr_q         <= wr_ptr_q + AW'(1);
                end
                if (clear_coeffs_i)
                    for (int i = 0; i < MAX_TAPS; i++) w_q[i] <= '0;
                if (pair) begin
                    err_q       <= err_d;
                    err_valid_q <= 1'b1;
                    y_have_q    <= 1'b0;
                    d_have_q    <= 1'b0;
                    if (y_valid_i || d_valid_i) overrun_q <= 1'b1;
                    if (adapt_en_i) begin
                        taps_q  <= taps_d;
                        mu_q    <= mu_shift_i;
                        k_q     <= '0;
                        state_q <= UPDATE;
                    end
                end else begin
                    if (y_valid_i) begin
                        y_pend_q <= y_data_i;
                        y_have_q <= 1'b1;
                        if (y_have_q) overrun_q <= 1'b1;
                    end
                    if (d_valid_i) begin
                        d_pend_q <= d_data_i;
                        d_have_q <= 1'b1;
                        if (d_have_q) overrun_q <= 1'b1;
                    end
                end
            end else begin
                if (x_valid_i || y_valid_i || d_valid_i) overrun_q <= 1'b1;
                // k counts beats issued; k==taps with a free register means the last beat was taken
                if (free) begin
                    if (k_q == taps_q) begin
                        coeff_valid_q <= 1'b0;
                        coeff_first_q <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        w_q[k_q[AW-1:0]] <= w_d;
                        coeff_q          <= w_d;
                        coeff_valid_q    <= 1'b1;
                        coeff_first_q    <= (k_q == '0);
                        k_q              <= k_q + KW'(1);
                    end
                end
            end
        end
    end

    assign error_out_o       = err_q;
    assign error_valid_o     = err_valid_q;
    assign coeff_out_o       = coeff_q;
    assign coeff_out_valid_o = coeff_valid_q;
    assign coeff_first_o     = coeff_first_q;
    assign busy_o            = (state_q == UPDATE);
    assign overrun_o         = overrun_q;
endmodule
